spio_hss_multiplexer_pkt_arbiter: RTL
=====================================

// Module: spio_hss_multiplexer_pkt_arbiter
// PURPOSE
//   Round-robin merge of NUM_CH independent packet streams into a single
//   registered packet stream. Sits directly upstream of the packet sync FIFO
//   and drives its write-side interface (SFI_DATA/SFI_VLD/SFI_RDY).
//   Fair, full-throughput (1 packet/cycle), 1-cycle latency.
// PARAMETERS
//   NUM_CH  4  number of input channels (2..8); pointer width = clog2(NUM_CH)
//   Packet width is `PKT_BITS from spio_hss_multiplexer_common.h.
// PORTS
//   CLK_IN         in   1                  clock (single clock domain)
//   RESET_IN       in   1                  synchronous, active-high reset
//   PKT_DATA_IN    in   NUM_CH*`PKT_BITS   ch i at [i*`PKT_BITS +: `PKT_BITS]
//   PKT_VLD_IN     in   NUM_CH             per-channel valid
//   PKT_RDY_OUT    out  NUM_CH             per-channel ready (one-hot or 0)
//   SFI_DATA_OUT   out  `PKT_BITS          merged packet to sync FIFO
//   SFI_VLD_OUT    out  1                  merged valid
//   SFI_RDY_IN     in   1                  sync FIFO ready
//   CNT_CLR_IN     in   1                  clear stats counters (see CONFIG)
//   PKT_CNT_OUT    out  NUM_CH*16          per-channel grant counters
// BEHAVIOUR
//   - Reset (RESET_IN high at CLK_IN edge): SFI_VLD_OUT=0, SFI_DATA_OUT=0,
//     last-grant pointer=NUM_CH-1 (ch 0 wins first), PKT_CNT_OUT=0.
//     PKT_RDY_OUT=0 while RESET_IN high. Reset mid-transfer drops the held
//     output packet; no partial state survives.
//   - Transfer on any interface: VLD && RDY at rising CLK_IN.
//   - load = !SFI_VLD_OUT || SFI_RDY_IN (output register empty or draining).
//   - grant: first i with PKT_VLD_IN[i]=1 searching last+1, last+2, ...
//     modulo NUM_CH (wraps NUM_CH-1 -> 0). Combinational from registered
//     pointer and PKT_VLD_IN.
//   - PKT_RDY_OUT = onehot(grant) when load && any valid, else 0. Ready may
//     depend on valid; SFI_VLD_OUT never depends on SFI_RDY_IN combinationally.
//   - On transfer from ch g: SFI_DATA_OUT<=PKT_DATA_IN[g], SFI_VLD_OUT<=1,
//     pointer<=g. Latency input->output: 1 cycle.
//   - If load && no input valid: SFI_VLD_OUT<=0, data/pointer hold.
//   - If !load (SFI_VLD_OUT=1, SFI_RDY_IN=0): output data/valid hold stable,
//     all PKT_RDY_OUT=0, pointer holds.
//   - Simultaneous drain+fill: output consumed and refilled same edge; no
//     bubble; sustained 1 packet/cycle with SFI_RDY_IN held high.
//   - Single active channel: granted every cycle (no idle slots for others).
//   - Pointer advances only on a transfer; an idle cycle never skips a channel.
//   - Upstream contract: PKT_DATA_IN[i] stable while PKT_VLD_IN[i]=1 and not
//     yet accepted; arbiter never accepts two packets in one cycle.
// CONFIGURATION
//   Macro SPIO_PKT_ARB_STATS_EN:
//   - defined: PKT_CNT_OUT[i] +1 on each accepted packet from ch i, 16-bit,
//     saturates at 16'hFFFF (no wrap). CNT_CLR_IN=1 zeroes all counters on
//     that edge; clear has priority over a same-cycle increment.
//   - undefined: PKT_CNT_OUT tied to 0, CNT_CLR_IN ignored, no counter flops;
//     arbitration behaviour identical.
// TESTING
//   1 All 4 ch valid, SFI_RDY_IN=1 for 8 cycles -> grants 0,1,2,3,0,1,2,3;
//     SFI_VLD_OUT=1 every cycle from cycle 1; data matches grant order.
//   2 Ch1,ch3 valid, SFI_RDY_IN=0 for 5 cycles after first accept (ch1) ->
//     SFI_DATA_OUT=ch1 data held, PKT_RDY_OUT=0; on release ch3 next, then ch1.
//   3 Only ch2 valid with 10 packets, RDY=1 -> 10 consecutive outputs,
//     no bubbles, pointer=2 afterwards; then ch0 valid -> ch0 granted next.
//   4 RESET_IN pulsed while SFI_VLD_OUT=1 and RDY=0 -> next cycle
//     SFI_VLD_OUT=0, PKT_RDY_OUT=0; after release ch0 served first.
//   5 (STATS_EN) 70000 ch0 packets -> PKT_CNT_OUT[15:0]=16'hFFFF; CNT_CLR_IN
//     with concurrent ch0 accept -> counter=0 next cycle.
//   6 Random valid/ready (10k cycles) vs scoreboard -> no loss, no dup,
//     per-channel order kept, no channel starved >NUM_CH-1 grants.

Source files
------------

// File: rtl/spio_hss_multiplexer_pkt_arbiter.sv
// ----------------------------------------------------------------------------
// spio_hss_multiplexer_pkt_arbiter
//
// Round-robin merge of NUM_CH packet streams into one registered stream that
// feeds the write side of the packet sync FIFO. The arbiter takes one packet
// per cycle, has one cycle of latency, and leaves no gap between packets when
// the output drains and refills on the same edge.
//
// Optional feature: when SPIO_PKT_ARB_STATS_EN is defined, each channel gets a
// saturating 16-bit counter of accepted packets. When it is undefined,
// PKT_CNT_OUT is tied to zero, CNT_CLR_IN is ignored and no counter flops are
// built. Arbitration is the same in both builds.
//
// Ports
//   CLK_IN        in   clock (single domain)
//   RESET_IN      in   synchronous active-high reset
//   PKT_DATA_IN   in   NUM_CH packets; ch i at [i*PKT_BITS +: PKT_BITS]
//   PKT_VLD_IN    in   per-channel valid
//   PKT_RDY_OUT   out  per-channel ready (one-hot or zero, combinational)
//   SFI_DATA_OUT  out  merged packet to the sync FIFO (registered)
//   SFI_VLD_OUT   out  merged valid (registered)
//   SFI_RDY_IN    in   sync FIFO ready
//   CNT_CLR_IN    in   clear all statistics counters
//   PKT_CNT_OUT   out  per-channel 16-bit grant counters, ch i at [i*16 +: 16]
// ----------------------------------------------------------------------------

`ifndef PKT_BITS
`define PKT_BITS 72
`endif

module spio_hss_multiplexer_pkt_arbiter #(
    parameter int unsigned NUM_CH = 4
) (
    input  logic                           CLK_IN,
    input  logic                           RESET_IN,
    input  logic [NUM_CH*`PKT_BITS-1:0]    PKT_DATA_IN,
    input  logic [NUM_CH-1:0]              PKT_VLD_IN,
    output logic [NUM_CH-1:0]              PKT_RDY_OUT,
    output logic [`PKT_BITS-1:0]           SFI_DATA_OUT,
    output logic                           SFI_VLD_OUT,
    input  logic                           SFI_RDY_IN,
    input  logic                           CNT_CLR_IN,
    output logic [NUM_CH*16-1:0]           PKT_CNT_OUT
);

    localparam int unsigned PKT_W = `PKT_BITS;
    localparam int unsigned PTR_W = $clog2(NUM_CH);
    localparam int unsigned CNT_W = 16;

    // Output register and last-grant pointer
    logic [PKT_W-1:0] data_q;
    logic             vld_q;
    logic [PTR_W-1:0] last_q;

    // Arbitration results
    logic [PTR_W-1:0] grant_c;
    logic             any_vld_c;
    logic             load_c;
    logic             accept_c;
    logic [PKT_W-1:0] sel_data_c;

    // First valid channel after 'last', wrapping modulo NUM_CH.
    function automatic logic [PTR_W-1:0] rr_pick(
        input logic [PTR_W-1:0]  last,
        input logic [NUM_CH-1:0] vld
    );
        logic [PTR_W-1:0] pick;
        logic             found;
        int unsigned      idx;
        pick  = last;
        found = 1'b0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            idx = (32'(last) + k) % NUM_CH;
            if (!found && vld[PTR_W'(idx)]) begin
                found = 1'b1;
                pick  = PTR_W'(idx);
            end
        end
        return pick;
    endfunction

    // Grant selection, handshake qualification and ready generation
    always_comb begin
        grant_c     = rr_pick(last_q, PKT_VLD_IN);
        any_vld_c   = |PKT_VLD_IN;
        // Output register can take a new packet when empty or being drained.
        load_c      = !vld_q || SFI_RDY_IN;
        // Nothing is accepted while reset is held.
        accept_c    = load_c && any_vld_c && !RESET_IN;
        PKT_RDY_OUT = '0;
        if (accept_c) begin
            PKT_RDY_OUT = NUM_CH'(1) << grant_c;
        end
        sel_data_c  = PKT_DATA_IN[32'(grant_c)*PKT_W +: PKT_W];
    end

    // Output register and round-robin pointer
    always_ff @(posedge CLK_IN) begin
        if (RESET_IN) begin
            data_q <= '0;
            vld_q  <= 1'b0;
            // Point at the last channel so ch 0 wins first after reset.
            last_q <= PTR_W'(NUM_CH - 1);
        end else if (load_c) begin
            if (any_vld_c) begin
                data_q <= sel_data_c;
                vld_q  <= 1'b1;
                last_q <= grant_c;
            end else begin
                vld_q  <= 1'b0;
            end
        end
    end

    assign SFI_DATA_OUT = data_q;
    assign SFI_VLD_OUT  = vld_q;

`ifdef SPIO_PKT_ARB_STATS_EN
    // Per-channel saturating accept counters; clear wins over increment.
    logic [NUM_CH-1:0][CNT_W-1:0] cnt_q;

    always_ff @(posedge CLK_IN) begin
        if (RESET_IN) begin
            cnt_q <= '0;
        end else if (CNT_CLR_IN) begin
            cnt_q <= '0;
        end else if (accept_c && (cnt_q[grant_c] != {CNT_W{1'b1}})) begin
            cnt_q[grant_c] <= cnt_q[grant_c] + CNT_W'(1);
        end
    end

    assign PKT_CNT_OUT = cnt_q;
`else
    // Statistics disabled: counters absent, clear input intentionally unused.
    logic stats_unused;
    assign stats_unused = CNT_CLR_IN;
    assign PKT_CNT_OUT  = '0;
`endif

endmodule
